// File: rtl/riscv_pkg.sv
// Shared fetch-side types: bubble encoding, fetch FSM states, IF/ID bundle.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
            q.pc    <= 32'd0;
            q.pc4   <= 32'd4;
        end else if (bubble) begin
            // a bubble keeps the old pc/pc4 so decode sees stable addresses
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, drives IMEM, fills IF/ID and traps illegal fetch targets.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) << 2;

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n, pc4;
    logic         fault_n;
    logic [31:0]  fault_pc_n, count_n;
    logic         load, bubble;
    logic         seq_over, redir_bad;
    if_id_t       id_d, id_q;

    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;
    assign seq_over  = (pc4 >= PC_LIMIT);
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);

    assign id_d = '{valid: 1'b1, instr: imem_instr, pc: pc, pc4: pc4};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fault       <= fault_n;
            fault_pc    <= fault_pc_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fault_n    = fault;
        fault_pc_n = fault_pc;
        count_n    = fetch_count;
        load       = 1'b0;
        bubble     = 1'b0;
        unique case (state)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    bubble = 1'b1;
                    if (redir_bad) begin
                        state_n    = FAULT;
                        fault_n    = 1'b1;
                        fault_pc_n = redirect_pc;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (flush) begin
                    bubble = 1'b1;
                    if (!stall) begin
                        if (seq_over) begin
                            state_n    = FAULT;
                            fault_n    = 1'b1;
                            fault_pc_n = pc4;
                        end else begin
                            pc_n = pc4;
                        end
                    end
                end else if (!stall) begin
                    // last legal word is still delivered on overrun
                    load = 1'b1;
                    if (fetch_count != 32'hFFFF_FFFF) begin
                        count_n = fetch_count + 32'd1;
                    end
                    if (seq_over) begin
                        state_n    = FAULT;
                        fault_n    = 1'b1;
                        fault_pc_n = pc4;
                    end else begin
                        pc_n = pc4;
                    end
                end
            end
            FAULT: begin
                bubble = 1'b1;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bubble (bubble),
        .d      (id_d),
        .q      (id_q)
    );

    assign id_valid = id_q.valid;
    assign id_instr = id_q.instr;
    assign id_pc    = id_q.pc;
    assign id_pc4   = id_q.pc4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational ADDI-program IMEM.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_instr;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc4;
    logic        fault;
    logic [31:0] fault_pc, fetch_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:2]];

    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL %s id_valid got %h want 0", tag, id_valid); end
        tests++; if (id_instr !== 32'h13) begin fails++; $display("FAIL %s id_instr got %h want 00000013", tag, id_instr); end
        tests++; if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin fails++; $display("FAIL %s id_pc/pc4 got %h/%h want 0/4", tag, id_pc, id_pc4); end
        tests++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin fails++; $display("FAIL %s fault/fault_pc got %h/%h want 0/0", tag, fault, fault_pc); end
        tests++; if (fetch_count !== 32'h0) begin fails++; $display("FAIL %s fetch_count got %h want 0", tag, fetch_count); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL %s imem_addr got %h want 0", tag, imem_addr); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        chk_reset_vals("reset");
        tick();
        reset = 1'b0;
        tick();
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL boot_no_capture id_valid got %h want 0", id_valid); end
    endtask

    task automatic test_free_run();
        tick();
        tests++; if (id_pc !== 32'h0 || id_instr !== 32'h0000_8093 || id_valid !== 1'b1) begin fails++; $display("FAIL run0 pc/instr/v got %h/%h/%h want 0/00008093/1", id_pc, id_instr, id_valid); end
        tick();
        tests++; if (id_pc !== 32'h4 || id_instr !== 32'h0010_8093 || id_pc4 !== 32'h8) begin fails++; $display("FAIL run1 pc/instr/pc4 got %h/%h/%h want 4/00108093/8", id_pc, id_instr, id_pc4); end
        tests++; if (fetch_count !== 32'd2 || imem_addr !== 32'h8) begin fails++; $display("FAIL run1 count/addr got %0d/%h want 2/8", fetch_count, imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (imem_addr !== 32'h8 || id_pc !== 32'h4 || id_valid !== 1'b1 || fetch_count !== 32'd2) begin fails++; $display("FAIL stall%0d addr/id_pc/v/count got %h/%h/%h/%0d want 8/4/1/2", i, imem_addr, id_pc, id_valid, fetch_count); end
        end
        stall = 1'b0;
        tick();
        tests++; if (id_pc !== 32'h8 || id_instr !== 32'h0020_8093 || fetch_count !== 32'd3) begin fails++; $display("FAIL stall_resume pc/instr/count got %h/%h/%0d want 8/00208093/3", id_pc, id_instr, fetch_count); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        stall          = 1'b1;
        tick();
        tests++; if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'h8) begin fails++; $display("FAIL redir_bubble v/instr/pc got %h/%h/%h want 0/00000013/8", id_valid, id_instr, id_pc); end
        tests++; if (imem_addr !== 32'h40 || fetch_count !== 32'd3) begin fails++; $display("FAIL redir_addr addr/count got %h/%0d want 40/3", imem_addr, fetch_count); end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        tick();
        tests++; if (id_pc !== 32'h40 || id_pc4 !== 32'h44 || id_instr !== 32'h0100_8093 || id_valid !== 1'b1) begin fails++; $display("FAIL redir_target pc/pc4/instr/v got %h/%h/%h/%h want 40/44/01008093/1", id_pc, id_pc4, id_instr, id_valid); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        tests++; if (id_valid !== 1'b0 || imem_addr !== 32'h48 || fetch_count !== 32'd4 || id_pc !== 32'h40) begin fails++; $display("FAIL flush v/addr/count/pc got %h/%h/%0d/%h want 0/48/4/40", id_valid, imem_addr, fetch_count, id_pc); end
        stall = 1'b1;
        tick();
        tests++; if (imem_addr !== 32'h48 || id_valid !== 1'b0) begin fails++; $display("FAIL flush_stall addr/v got %h/%h want 48/0", imem_addr, id_valid); end
        flush = 1'b0;
        stall = 1'b0;
        tick();
        tests++; if (id_pc !== 32'h48 || id_instr !== 32'h0120_8093 || fetch_count !== 32'd5) begin fails++; $display("FAIL flush_resume pc/instr/count got %h/%h/%0d want 48/01208093/5", id_pc, id_instr, fetch_count); end
    endtask

    task automatic test_overrun();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F8;
        tick();
        redirect_valid = 1'b0;
        tests++; if (imem_addr !== 32'h3F8 || id_valid !== 1'b0) begin fails++; $display("FAIL ovr_redir addr/v got %h/%h want 3f8/0", imem_addr, id_valid); end
        tick();
        tests++; if (id_pc !== 32'h3F8 || id_valid !== 1'b1 || fault !== 1'b0) begin fails++; $display("FAIL ovr_3f8 pc/v/fault got %h/%h/%h want 3f8/1/0", id_pc, id_valid, fault); end
        tick();
        tests++; if (id_pc !== 32'h3FC || id_valid !== 1'b1 || id_instr !== 32'h0FF0_8093) begin fails++; $display("FAIL ovr_3fc pc/v/instr got %h/%h/%h want 3fc/1/0ff08093", id_pc, id_valid, id_instr); end
        tests++; if (fault !== 1'b1 || fault_pc !== 32'h400) begin fails++; $display("FAIL ovr_fault fault/fault_pc got %h/%h want 1/400", fault, fault_pc); end
        tick();
        tests++; if (id_valid !== 1'b0 || fault !== 1'b1) begin fails++; $display("FAIL ovr_after v/fault got %h/%h want 0/1", id_valid, fault); end
        reset = 1'b1;
        #2;
        chk_reset_vals("reset_in_fault");
        reset = 1'b0;
        tick();
        tick();
        tests++; if (id_pc !== 32'h0 || id_valid !== 1'b1 || fetch_count !== 32'd1) begin fails++; $display("FAIL restart pc/v/count got %h/%h/%0d want 0/1/1", id_pc, id_valid, fetch_count); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        tests++; if (fault !== 1'b1 || fault_pc !== 32'h42 || id_valid !== 1'b0) begin fails++; $display("FAIL misal fault/fault_pc/v got %h/%h/%h want 1/42/0", fault, fault_pc, id_valid); end
        redirect_pc = 32'h0;
        tick();
        tick();
        redirect_valid = 1'b0;
        tests++; if (fault !== 1'b1 || fault_pc !== 32'h42 || id_valid !== 1'b0 || imem_addr !== 32'h4) begin fails++; $display("FAIL misal_sticky fault/fault_pc/v/addr got %h/%h/%h/%h want 1/42/0/4", fault, fault_pc, id_valid, imem_addr); end
    endtask

    task automatic test_reset_mid_stall();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        tests++; if (id_pc !== 32'h4 || imem_addr !== 32'h8) begin fails++; $display("FAIL pre_stall pc/addr got %h/%h want 4/8", id_pc, imem_addr); end
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("reset_mid_stall");
        stall = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        tick();
        tests++; if (id_pc !== 32'h0 || id_instr !== 32'h0000_8093 || fetch_count !== 32'd1) begin fails++; $display("FAIL restart2 pc/instr/count got %h/%h/%0d want 0/00008093/1", id_pc, id_instr, fetch_count); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (32'(i) << 20) | 32'h0000_8093;
        end
        reset          = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_flush();
        test_overrun();
        test_misaligned();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
